// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shifter: op codes, FSM states, default width.
package shift_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift of a WIDTH-bit word, selected by op.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = {a[WIDTH-2:0], 1'b0};
    case (op_e'(op))
      SH_SLL:  y = {a[WIDTH-2:0], 1'b0};
      SH_SRL:  y = {1'b0, a[WIDTH-1:1]};
      SH_SRA:  y = {a[WIDTH-1], a[WIDTH-1:1]};
      SH_ROR:  y = {a[0], a[WIDTH-1:1]};
      default: y = {a[WIDTH-2:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative variable-amount shifter: one bit per cycle, start/busy/done handshake.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc, acc_step;
  logic [SHAMT_W-1:0] cnt;
  logic [1:0]         op_r;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .a  (acc),
    .op (op_r),
    .y  (acc_step)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (shamt == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (cnt == SHAMT_W'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // result is loaded only on the edge that enters DONE, so it holds through IDLE/SHIFT
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      cnt    <= '0;
      op_r   <= SH_SLL;
      result <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          acc  <= data;
          cnt  <= shamt;
          op_r <= op;
          if (shamt == '0) result <= data;
        end
        S_SHIFT: begin
          acc <= acc_step;
          cnt <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) result <= acc_step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: stimulus pushes expected result/done cycle, monitor pops on done.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic [31:0] data;
  logic [4:0]  shamt;
  logic        busy, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nb;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t sbq[$];

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .data   (data),
    .shamt  (shamt),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, want, cyc);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done with result %h want no done (cyc %0d)", result, cyc);
      end else begin
        e = sbq.pop_front();
        chk("done_result", result, e.res);
        chk("done_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic issue(input logic [31:0] d, input logic [1:0] o, input logic [4:0] s,
                       input logic [31:0] want);
    exp_t e;
    @(negedge clk);
    data  = d;
    op    = o;
    shamt = s;
    start = 1'b1;
    e.res = want;
    e.at  = cyc + 1 + int'(s);
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    data  = $urandom;
    op    = 2'($urandom);
    shamt = 5'($urandom);
  endtask

  // counts busy cycles from the first cycle after acceptance; result must hold before DONE
  task automatic wait_idle(input logic [31:0] prev, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      n++;
      if (!done) chk("result_hold", result, prev);
      @(negedge clk);
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: got busy=1 want busy=0 within 40 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; data = '0; shamt = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'h0);
    rst = 1'b0;

    issue(32'h0000_0001, 2'b00, 5'd4, 32'h0000_0010);
    wait_idle(32'h0, nb);
    chk("sll_busy_cycles", 32'(nb), 32'd5);

    issue(32'h8000_0000, 2'b10, 5'd31, 32'hFFFF_FFFF);
    wait_idle(32'h0000_0010, nb);
    chk("sra_busy_cycles", 32'(nb), 32'd32);

    issue(32'h8000_0000, 2'b01, 5'd31, 32'h0000_0001);
    wait_idle(32'hFFFF_FFFF, nb);

    issue(32'hDEAD_BEEF, 2'b11, 5'd0, 32'hDEAD_BEEF);
    wait_idle(32'h0000_0001, nb);
    chk("zero_busy_cycles", 32'(nb), 32'd1);

    issue(32'h0000_00F1, 2'b11, 5'd4, 32'h1000_000F);
    wait_idle(32'hDEAD_BEEF, nb);

    // start re-raised during SHIFT and during DONE must be ignored
    issue(32'h0000_00F0, 2'b01, 5'd4, 32'h0000_000F);
    @(negedge clk);
    start = 1'b1; data = 32'h1234_5678; op = 2'b00; shamt = 5'd0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("ign_done_seen", 32'(done), 32'd1);
    start = 1'b1; data = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy_after", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("ign_result", result, 32'h0000_000F);
    chk("ign_busy_idle", 32'(busy), 32'd0);

    // reset in the third SHIFT cycle abandons the op
    @(negedge clk);
    data = 32'h1; op = 2'b00; shamt = 5'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_result", result, 32'h0);
    repeat (15) @(negedge clk);
    chk("mid_rst_idle", 32'(busy), 32'd0);

    // rst and start together: rst wins
    rst = 1'b1; start = 1'b1; data = 32'h5; shamt = 5'd0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rst_start_done", 32'(done), 32'd0);
    chk("rst_start_result", result, 32'h0);

    issue(32'h0000_0003, 2'b00, 5'd2, 32'h0000_000C);
    wait_idle(32'h0, nb);
    chk("fresh_busy_cycles", 32'(nb), 32'd3);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
